// File: rtl/display_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-aligned source selector.
// Build option: define SEG_ACTIVE_LOW_EN for common-anode boards (inverted seg_out/dig_en).
module display_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 100,
    parameter int ALT_FRAMES   = 250
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    output logic                    selector,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_end
);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    localparam int CNT_MAX = (BLANK_CYCLES > REFRESH_DIV - 1) ? BLANK_CYCLES : REFRESH_DIV - 1;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W   = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;

    localparam logic [6:0]            SEG_OFF = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{POL}};
    localparam logic [NUM_DIGITS-1:0] ONE     = NUM_DIGITS'(1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic [IDX_W-1:0]              idx;
    logic [FRM_W-1:0]              frame_cnt;
    logic [NUM_DIGITS-1:0][6:0]    digit;
    logic                          last_digit;
    logic [IDX_W-1:0]              nidx;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_slice
        assign digit[k] = seg_in[7*k +: 7];
    end

    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign nidx       = last_digit ? '0 : idx + IDX_W'(1);

    // The SHOW-end clock already counts as the first blank clock, so a
    // post-SHOW BLANK starts at cnt=1; entry from IDLE starts at cnt=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            selector  <= 1'b0;
            seg_out   <= SEG_OFF;
            dig_en    <= DIG_OFF;
            frame_end <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                idx     <= '0;
                seg_out <= SEG_OFF;
                dig_en  <= DIG_OFF;
            end else begin
                case (state)
                    IDLE: begin
                        state <= BLANK;
                        cnt   <= '0;
                    end
                    BLANK: begin
                        if (cnt == CNT_W'(BLANK_CYCLES)) begin
                            state   <= SHOW;
                            cnt     <= '0;
                            seg_out <= SEG_OFF ^ digit[idx];
                            dig_en  <= DIG_OFF ^ (ONE << idx);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    SHOW: begin
                        if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                            idx <= nidx;
                            if (last_digit) begin
                                frame_end <= 1'b1;
                                if (frame_cnt == FRM_W'(ALT_FRAMES - 1)) begin
                                    frame_cnt <= '0;
                                    selector  <= ~selector;
                                end else begin
                                    frame_cnt <= frame_cnt + FRM_W'(1);
                                end
                            end
                            if (BLANK_CYCLES == 0) begin
                                cnt     <= '0;
                                seg_out <= SEG_OFF ^ digit[nidx];
                                dig_en  <= DIG_OFF ^ (ONE << nidx);
                            end else begin
                                state   <= BLANK;
                                cnt     <= CNT_W'(1);
                                seg_out <= SEG_OFF;
                                dig_en  <= DIG_OFF;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        seg_out <= SEG_OFF;
                        dig_en  <= DIG_OFF;
                    end
                endcase
            end
        end
    end

    a_dig_onehot: assert property (@(posedge clk) disable iff (!reset_n)
                                   $onehot0(dig_en ^ DIG_OFF));

endmodule
